alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised, registered ALU execute unit for the ARMv4 datapath. It accepts one operation per valid/ready handshake, decodes the 4-bit data-processing opcode, and returns a WIDTH-bit result with NZCV flags and a write-enable. It also runs iterative multi-cycle MUL/MLA, which a purely combinational select decoder cannot do. It sits between register-read and write-back and applies backpressure through ready signals.

## Interface
- WIDTH, 32: operand/result width; ≥ 8, multiple of MBITS.
- MBITS, 1: multiplier bits retired per MUL cycle; 1, 2 or 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- alufun  in  4  opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
- mul  in  1  multiply request; alufun ignored.
- acc  in  1  with mul, MLA (a*b+c), else MUL (a*b).
- a, b, c  in  WIDTH  operands; c used only by MLA.
- cin, vin  in  1  incoming C and V flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result.
- nzcv  out  4  {N,Z,C,V}.
- wr_en  out  1  result must be written back.

## Operation
- States: IDLE, MULT, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Request accepted when in_valid && in_ready. Operands are captured on the accept edge.
- Non-mul request: result is computed and registered on the accept edge. Next: out_valid=1, state stays IDLE.
- Arithmetic is WIDTH+1-bit:
  - ADD = a+b, ADC = a+b+cin.
  - SUB = a+~b+1, SBC = a+~b+cin.
  - RSB/RSC swap a and b.
  - CMP behaves as SUB; CMN behaves as ADD.
  - C = carry-out (subtracts: C = NOT borrow).
  - V = signed overflow: operand MSBs equal after inversion and result MSB differs.
- Logic ops: AND, EOR, ORR, MOV = b, BIC = a&~b, MVN = ~b; TST behaves as AND; TEQ behaves as EOR. C = cin, V = vin.
- N = result[WIDTH-1]; Z = (result==0) for all ops.
- wr_en = 0 for TST/TEQ/CMP/CMN (alufun 8-B); 1 for all other ops, including MUL/MLA.
- MUL/MLA:
  - Accept loads multiplicand = a, multiplier = b, acc = (acc ? c : 0), count = WIDTH/MBITS; state goes to MULT.
  - Each MULT cycle adds (multiplier[MBITS-1:0] * multiplicand) to acc, shifts multiplicand left and multiplier right by MBITS, and decrements count.
  - When count reaches 1, the final sum is written to result, nzcv = {N,Z,cin,vin}, out_valid=1, and state goes to HOLD.
  - Arithmetic is modulo 2^WIDTH (low half only).
- HOLD goes to IDLE when the result is consumed (out_valid && out_ready); in_ready is 0 in HOLD.
- out_valid clears on out_valid && out_ready unless a new non-mul result is registered the same edge; in that case out_valid stays 1 with the new data.
- result, nzcv and wr_en stay stable while out_valid && !out_ready.
- Reset values: state IDLE; out_valid 0; result 0; nzcv 0000; wr_en 0; count 0; in_ready 1 once rst_n is high.
- Reset mid-MULT aborts the operation; no result is produced.

## Timing
- Non-mul latency: 1 cycle (result valid the edge after accept). Throughput is 1 per cycle with out_ready held high.
- MUL latency: WIDTH/MBITS cycles from accept to out_valid (32 at defaults, 8 at MBITS=4).
- The next request is accepted no earlier than the cycle in which the MUL result is consumed.
- in_ready is combinational from state, out_valid and out_ready; no path from in_valid to in_ready.
- Operand inputs are don't-care outside the accept cycle.

## Test plan
- Reset then ADD: a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result=0x80000000, nzcv=1001, wr_en=1.
- CMP a=5, b=5 with out_ready=1 -> result 0, nzcv=0110, wr_en=0. Back-to-back SUB a=3, b=5 the following cycle -> 0xFFFFFFFE, nzcv=1000.
- Backpressure: issue EOR, hold out_ready=0 for 3 cycles -> in_ready=0 and outputs stable. Raise out_ready -> the held result is consumed and the next request is accepted the same cycle.
- MLA a=0x10000, b=0x10000, c=7, cin=1, vin=0, MBITS=1 -> out_valid exactly 32 cycles after accept, result=7, nzcv=0010. Repeat at MBITS=4 -> 8 cycles.
- Assert rst_n low at MULT cycle 10 -> out_valid stays 0, state IDLE, in_ready=1 after release, no spurious result.
- WIDTH=8 build: ADC a=0xFF, b=0x00, cin=1 -> result 0x00, nzcv=0110. MVN b=0x0F, cin=0, vin=1 -> result 0xF0, nzcv=1001.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Registered ARMv4 ALU execute stage with valid/ready handshakes.
// Data-processing ops take one cycle; MUL/MLA iterate MBITS multiplier bits per cycle.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MBITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alufun,
  input  logic             mul,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cin,
  input  logic             vin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic             wr_en
);

  localparam int unsigned NSTEPS = WIDTH / MBITS;
  localparam int unsigned CNT_W  = $clog2(NSTEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_HOLD} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_nzcv;
  logic             r_wr_en;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_cin;
  logic             r_vin;

  op_t              w_op;
  logic             w_accept;
  logic             w_arith;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ci;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_wr;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_mac;

  assign w_op      = op_t'(alufun);
  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign nzcv      = r_nzcv;
  assign wr_en     = r_wr_en;

  // Every arithmetic op is mapped onto x + y + ci; subtracts present ~operand.
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_ci    = 1'b0;
    w_arith = 1'b1;
    case (w_op)
      OP_SUB, OP_CMP: begin w_y = ~b; w_ci = 1'b1; end
      OP_RSB:         begin w_x = b; w_y = ~a; w_ci = 1'b1; end
      OP_ADD, OP_CMN: w_ci = 1'b0;
      OP_ADC:         w_ci = cin;
      OP_SBC:         begin w_y = ~b; w_ci = cin; end
      OP_RSC:         begin w_x = b; w_y = ~a; w_ci = cin; end
      default:        w_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};

  always_comb begin
    w_logic = '0;
    case (w_op)
      OP_AND, OP_TST: w_logic = a & b;
      OP_EOR, OP_TEQ: w_logic = a ^ b;
      OP_ORR:         w_logic = a | b;
      OP_MOV:         w_logic = b;
      OP_BIC:         w_logic = a & ~b;
      OP_MVN:         w_logic = ~b;
      default:        w_logic = '0;
    endcase
  end

  assign w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
  assign w_c   = w_arith ? w_sum[WIDTH] : cin;
  assign w_v   = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != w_x[WIDTH-1])) : vin;
  assign w_wr  = (alufun[3:2] != 2'b10);

  // Partial product of the low MBITS multiplier bits, built as shifted adds.
  always_comb begin
    w_partial = '0;
    for (int unsigned i = 0; i < MBITS; i++) begin
      if (r_mplier[i]) w_partial = w_partial + (r_mcand << i);
    end
  end

  assign w_mac = r_acc + w_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_nzcv      <= '0;
      r_wr_en     <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_cin       <= 1'b0;
      r_vin       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && mul) begin
            r_mcand     <= a;
            r_mplier    <= b;
            r_acc       <= acc ? c : '0;
            r_count     <= CNT_W'(NSTEPS);
            r_cin       <= cin;
            r_vin       <= vin;
            r_out_valid <= 1'b0;
            r_state     <= S_MULT;
          end else if (w_accept) begin
            r_result    <= w_res;
            r_nzcv      <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
            r_wr_en     <= w_wr;
            r_out_valid <= 1'b1;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MULT: begin
          r_acc    <= w_mac;
          r_mcand  <= r_mcand << MBITS;
          r_mplier <= r_mplier >> MBITS;
          r_count  <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_result    <= w_mac;
            r_nzcv      <= {w_mac[WIDTH-1], (w_mac == '0), r_cin, r_vin};
            r_wr_en     <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: 32-bit MBITS=1, 32-bit MBITS=4 and 8-bit builds.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alufun;
  logic        mul, acc, cin, vin;
  logic [31:0] a, b, c;
  logic [7:0]  a8, b8, c8;

  logic        iv1, ir1, ov1, or1, we1;
  logic [31:0] res1;
  logic [3:0]  f1;
  logic        iv4, ir4, ov4, or4, we4;
  logic [31:0] res4;
  logic [3:0]  f4;
  logic        iv8, ir8, ov8, or8, we8;
  logic [7:0]  res8;
  logic [3:0]  f8;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int spur;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .MBITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .alufun(alufun),
    .mul(mul), .acc(acc), .a(a), .b(b), .c(c), .cin(cin), .vin(vin),
    .out_valid(ov1), .out_ready(or1), .result(res1), .nzcv(f1), .wr_en(we1)
  );

  alu_seq_unit #(.WIDTH(32), .MBITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .alufun(alufun),
    .mul(mul), .acc(acc), .a(a), .b(b), .c(c), .cin(cin), .vin(vin),
    .out_valid(ov4), .out_ready(or4), .result(res4), .nzcv(f4), .wr_en(we4)
  );

  alu_seq_unit #(.WIDTH(8), .MBITS(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .alufun(alufun),
    .mul(mul), .acc(acc), .a(a8), .b(b8), .c(c8), .cin(cin), .vin(vin),
    .out_valid(ov8), .out_ready(or8), .result(res8), .nzcv(f8), .wr_en(we8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; alufun = 4'h0; mul = 1'b0; acc = 1'b0; cin = 1'b0; vin = 1'b0;
    a = '0; b = '0; c = '0; a8 = '0; b8 = '0; c8 = '0;
    iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0; or1 = 1'b1; or4 = 1'b1; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ir1), 32'h1);
    chk("rst_out_valid", 32'(ov1), 32'h0);
    chk("rst_result", res1, 32'h0);
    chk("rst_nzcv", 32'(f1), 32'h0);
    chk("rst_wr_en", 32'(we1), 32'h0);
    chk("rst_in_ready8", 32'(ir8), 32'h1);

    // ADD overflow into the sign bit
    alufun = 4'h4; a = 32'h7FFF_FFFF; b = 32'h1; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("add_valid", 32'(ov1), 32'h1);
    chk("add_result", res1, 32'h8000_0000);
    chk("add_nzcv", 32'(f1), 32'h9);
    chk("add_wr_en", 32'(we1), 32'h1);

    // CMP then back-to-back SUB
    alufun = 4'hA; a = 32'd5; b = 32'd5; iv1 = 1'b1;
    chk("cmp_in_ready", 32'(ir1), 32'h1);
    tick();
    chk("cmp_result", res1, 32'h0);
    chk("cmp_nzcv", 32'(f1), 32'h6);
    chk("cmp_wr_en", 32'(we1), 32'h0);
    alufun = 4'h2; a = 32'd3; b = 32'd5;
    tick();
    iv1 = 1'b0;
    chk("sub_valid", 32'(ov1), 32'h1);
    chk("sub_result", res1, 32'hFFFF_FFFE);
    chk("sub_nzcv", 32'(f1), 32'h8);
    chk("sub_wr_en", 32'(we1), 32'h1);
    tick();
    chk("sub_consumed", 32'(ov1), 32'h0);

    // Backpressure: EOR held three cycles while an ADD waits
    or1 = 1'b0; alufun = 4'h1; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; cin = 1'b1; vin = 1'b0;
    iv1 = 1'b1;
    tick();
    alufun = 4'h4; a = 32'd1; b = 32'd2; cin = 1'b0;
    chk("eor_result", res1, 32'h0FF0_0FF0);
    chk("eor_nzcv", 32'(f1), 32'h2);
    chk("eor_in_ready", 32'(ir1), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(ov1), 32'h1);
      chk("bp_in_ready", 32'(ir1), 32'h0);
      chk("bp_result", res1, 32'h0FF0_0FF0);
      chk("bp_nzcv", 32'(f1), 32'h2);
    end
    or1 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ir1), 32'h1);
    tick();
    iv1 = 1'b0;
    chk("bp_next_valid", 32'(ov1), 32'h1);
    chk("bp_next_result", res1, 32'h3);
    chk("bp_next_nzcv", 32'(f1), 32'h0);
    tick();
    chk("bp_next_consumed", 32'(ov1), 32'h0);

    // MLA on MBITS=1: 0x10000*0x10000 wraps to 0, plus 7
    or1 = 1'b0; mul = 1'b1; acc = 1'b1; a = 32'h1_0000; b = 32'h1_0000; c = 32'd7;
    cin = 1'b1; vin = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0; mul = 1'b0; acc = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; c = 32'hFFFF_FFFF;
    chk("mla1_busy_ready", 32'(ir1), 32'h0);
    lat = 0;
    while (!ov1 && lat < 40) begin tick(); lat++; end
    chk("mla1_latency", 32'(lat), 32'd32);
    chk("mla1_result", res1, 32'h7);
    chk("mla1_nzcv", 32'(f1), 32'h2);
    chk("mla1_wr_en", 32'(we1), 32'h1);
    tick();
    chk("mla1_hold_valid", 32'(ov1), 32'h1);
    chk("mla1_hold_result", res1, 32'h7);
    or1 = 1'b1;
    #1;
    chk("mla1_hold_ready", 32'(ir1), 32'h0);
    tick();
    chk("mla1_consumed", 32'(ov1), 32'h0);
    chk("mla1_idle_ready", 32'(ir1), 32'h1);

    // MLA on MBITS=1 with non-trivial operands: 0x1234*0x5678 + 0x10
    mul = 1'b1; acc = 1'b1; a = 32'h1234; b = 32'h5678; c = 32'h10; cin = 1'b0; vin = 1'b0;
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0; mul = 1'b0; acc = 1'b0;
    lat = 0;
    while (!ov1 && lat < 40) begin tick(); lat++; end
    chk("mla1b_latency", 32'(lat), 32'd32);
    chk("mla1b_result", res1, 32'h0626_0070);
    chk("mla1b_nzcv", 32'(f1), 32'h0);
    tick();
    chk("mla1b_consumed", 32'(ov1), 32'h0);

    // Same MLA as the first one on MBITS=4
    or4 = 1'b0; mul = 1'b1; acc = 1'b1; a = 32'h1_0000; b = 32'h1_0000; c = 32'd7;
    cin = 1'b1; vin = 1'b0; iv4 = 1'b1;
    tick();
    iv4 = 1'b0; mul = 1'b0; acc = 1'b0;
    lat = 0;
    while (!ov4 && lat < 40) begin tick(); lat++; end
    chk("mla4_latency", 32'(lat), 32'd8);
    chk("mla4_result", res4, 32'h7);
    chk("mla4_nzcv", 32'(f4), 32'h2);
    chk("mla4_wr_en", 32'(we4), 32'h1);
    chk("mla4_hold_ready", 32'(ir4), 32'h0);
    or4 = 1'b1;
    tick();
    chk("mla4_consumed", 32'(ov4), 32'h0);

    // MUL on MBITS=4: all-ones squared is 1 mod 2^32; c ignored
    mul = 1'b1; acc = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c = 32'd5;
    cin = 1'b0; vin = 1'b1; iv4 = 1'b1;
    tick();
    iv4 = 1'b0; mul = 1'b0;
    lat = 0;
    while (!ov4 && lat < 40) begin tick(); lat++; end
    chk("mul4_latency", 32'(lat), 32'd8);
    chk("mul4_result", res4, 32'h1);
    chk("mul4_nzcv", 32'(f4), 32'h1);
    tick();
    chk("mul4_consumed", 32'(ov4), 32'h0);
    chk("mul4_idle_ready", 32'(ir4), 32'h1);

    // Reset during the tenth MULT cycle aborts the multiply
    mul = 1'b1; acc = 1'b0; a = 32'd3; b = 32'd5; cin = 1'b0; vin = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0; mul = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid_in_rst", 32'(ov1), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(ir1), 32'h1);
    chk("abort_result", res1, 32'h0);
    spur = 0;
    repeat (40) begin
      tick();
      if (ov1) spur++;
    end
    chk("abort_no_result", 32'(spur), 32'h0);

    // 8-bit build: ADC wrap then MVN, back to back
    alufun = 4'h5; a8 = 8'hFF; b8 = 8'h00; cin = 1'b1; vin = 1'b0; iv8 = 1'b1;
    tick();
    alufun = 4'hF; b8 = 8'h0F; cin = 1'b0; vin = 1'b1;
    chk("adc8_result", 32'(res8), 32'h0);
    chk("adc8_nzcv", 32'(f8), 32'h6);
    chk("adc8_wr_en", 32'(we8), 32'h1);
    tick();
    iv8 = 1'b0;
    chk("mvn8_valid", 32'(ov8), 32'h1);
    chk("mvn8_result", 32'(res8), 32'hF0);
    chk("mvn8_nzcv", 32'(f8), 32'h9);
    tick();
    chk("mvn8_consumed", 32'(ov8), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
